// File: rtl/shift_norm_pkg.sv
// rtl/shift_norm_pkg.sv - shared FSM state type and mode encoding for the shift normaliser
package shift_norm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} statetype;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_ARITH    = 1'b1;

endpackage

// File: rtl/norm_detect.sv
// rtl/norm_detect.sv - combinational termination and degenerate-operand detection
module norm_detect
  import shift_norm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             mode_i,
  output logic             term_o,
  output logic             degen_o
);

  logic all_zero;
  logic all_ones;

  assign all_zero = (val_i == '0);
  assign all_ones = (val_i == {WIDTH{1'b1}});

  // Signed values are normalised once the sign bit differs from the bit below it.
  always_comb begin
    term_o  = 1'b0;
    degen_o = 1'b0;
    if (mode_i == MODE_ARITH) begin
      degen_o = all_zero | all_ones;
      term_o  = val_i[WIDTH-1] ^ val_i[WIDTH-2];
    end else begin
      degen_o = all_zero;
      term_o  = val_i[WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - iterative one-bit-per-cycle normaliser with start/done handshake
module shift_normalizer
  import shift_norm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [SHW-1:0]   shamt,
  output logic             zero
);

  statetype         state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             zero_q, zero_d;
  logic             term, degen;

  norm_detect #(.WIDTH(WIDTH)) u_detect (
    .val_i   (val_q),
    .mode_i  (mode_q),
    .term_o  (term),
    .degen_o (degen)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts directly so back-to-back operations skip the IDLE bubble.
        if (start) begin
          val_d   = din;
          cnt_d   = '0;
          mode_d  = arith;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (degen) begin
          state_d = DONE;
          dout_d  = val_q;
          shamt_d = '0;
          zero_d  = 1'b1;
        end else if (term) begin
          state_d = DONE;
          dout_d  = val_q;
          shamt_d = cnt_q;
          zero_d  = 1'b0;
        end else begin
          val_d = val_q << 1;
          cnt_d = cnt_q + SHW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_UNSIGNED;
      dout_q  <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign dout  = dout_q;
  assign shamt = shamt_q;
  assign zero  = zero_q;

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Iterative normaliser for the 8-bit MIPS datapath. It is the inverse of the barrel shifter: the shifter maps (din, shamt) to dout; this block takes a value and finds the left-shift amount that normalises it.
- Outputs are the normalised value and the shift count, which are valid operands for a later shifter right-shift that restores the original.
- Shifts one bit per cycle under a start/done handshake. Used by the multicycle controller for normalise/count-leading-zeros operations.

Parameters:
- WIDTH, 8, data width in bits; must be >= 4.
- SHW, 5, shamt width, matching the shifter's shamt port; 2**SHW must exceed WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- start  input  1  request; accepted only in IDLE or DONE.
- arith  input  1  0 = unsigned normalise (MSB set); 1 = signed normalise (bit W-1 != bit W-2). Sampled only on accept.
- din  input  WIDTH  operand, sampled only on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- dout  output  WIDTH  normalised value (din << shamt, truncated).
- shamt  output  SHW  number of left shifts applied.
- zero  output  1  degenerate operand: din==0 (unsigned), or din all-0s/all-1s (arith).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, dout=0, shamt=0, zero=0. Reset wins over start in the same cycle. Reset mid-RUN aborts the operation and no done is produced.
- Accept (start=1 in IDLE or DONE at edge E1): reg<=din, cnt<=0, mode<=arith, state<=RUN. start in RUN is ignored.
- RUN, evaluated on each edge, terminating conditions first:
  - Degenerate operand (reg==0 unsigned; reg==0 or reg=={WIDTH{1}} arith): state<=DONE, dout<=reg, shamt<=0, zero<=1.
  - Terminated (reg[W-1]==1 unsigned; reg[W-1]^reg[W-2] arith): state<=DONE, dout<=reg, shamt<=cnt, zero<=0.
  - Otherwise: reg<=reg<<1 with zero fill, cnt<=cnt+1.
- DONE: done=1 for exactly one cycle, then IDLE, unless start=1, which re-accepts (back-to-back operation, no IDLE bubble).
- Latency: with k shifts, done is high in the cycle after edge E(k+2), counting the accept edge as E1.
  - Bounds: unsigned k<=WIDTH-1; arith k<=WIDTH-2; degenerate k=0.
- Result hold: dout, shamt and zero hold their values from DONE until the next DONE or reset; they are not disturbed during RUN.
- Invariants for any non-degenerate result:
  - dout == (din << shamt) truncated to WIDTH.
  - Arith mode: arithmetic right shift of dout by shamt == din.
  - Unsigned mode: logical right shift of dout by shamt == din.
- shamt is zero-extended from cnt. cnt never exceeds WIDTH-1; the bench asserts this.

Decomposition:
- Package shift_norm_pkg:
  - typedef enum logic [1:0] statetype {IDLE, RUN, DONE}.
  - localparams for mode encoding (MODE_UNSIGNED=0, MODE_ARITH=1).
- Sub-module norm_detect (combinational): inputs reg value and mode; outputs term and degen flags. Keeps the FSM/datapath module free of the detection logic, and norm_detect is reusable in a future single-cycle leading-zero unit.
- The top holds the FSM, shift register, counter and result registers.

Test Plan:
- Reset: hold reset 2 cycles with start=1, din=0x55 -> busy=0, done=0, dout=0x00, shamt=0, zero=0; no done ever follows.
- Unsigned din=0x33 -> dout=0xCC, shamt=2, zero=0; done after E4. din=0x01 -> dout=0x80, shamt=7; done after E9.
- Unsigned din=0x00 -> zero=1, dout=0x00, shamt=0; done after E2. din=0xC5 -> dout=0xC5, shamt=0; done after E2.
- Arith din=0x05 -> dout=0x50, shamt=4. din=0xF5 -> dout=0xA8, shamt=3. din=0xFF -> zero=1, dout=0xFF, shamt=0. Check each result against the shifter: arith right shift of dout by shamt returns din.
- Reset mid-op: start din=0x01, reset at E4 -> no done, outputs 0. Then start din=0x33 -> dout=0xCC, shamt=2. start pulsed during RUN is ignored (result unchanged, same latency).
- Back-to-back: start held high through the DONE cycle with new din=0x10 -> second accept with no IDLE cycle; dout=0x80, shamt=3; done after 5 further edges; first result visible during the first done pulse.
